// File: rtl/id_ex_operand_stage_if.sv
// Bus between decode, the ID/EX operand stage, the EX/MEM and MEM/WB forwarding sources and the ALU.
// The master drives decode fields, forwarding buses and out_ready. The slave (the stage) drives the rest.
interface id_ex_operand_stage_if #(
   parameter int DATA_W = 32,
   parameter int FUNC_W = 6,
   parameter int REG_AW = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [FUNC_W-1:0] in_func;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic [REG_AW-1:0] in_rs;
   logic [REG_AW-1:0] in_rt;
   logic [REG_AW-1:0] in_rd;
   logic              exm_wr_en;
   logic [REG_AW-1:0] exm_rd;
   logic [DATA_W-1:0] exm_result;
   logic              wb_wr_en;
   logic [REG_AW-1:0] wb_rd;
   logic [DATA_W-1:0] wb_result;
   logic              out_valid;
   logic              out_ready;
   logic [FUNC_W-1:0] alu_func;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [REG_AW-1:0] alu_rd;
   logic              illegal_func;

   modport master (
      output in_valid, in_func, in_a, in_b, in_rs, in_rt, in_rd,
             exm_wr_en, exm_rd, exm_result, wb_wr_en, wb_rd, wb_result, out_ready,
      input  in_ready, out_valid, alu_func, alu_a, alu_b, alu_rd, illegal_func
   );

   modport slave (
      input  in_valid, in_func, in_a, in_b, in_rs, in_rt, in_rd,
             exm_wr_en, exm_rd, exm_result, wb_wr_en, wb_rd, wb_result, out_ready,
      output in_ready, out_valid, alu_func, alu_a, alu_b, alu_rd, illegal_func
   );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: one-entry valid/ready holding register in front of the ALU.
// When the macro ID_EX_FWD_EN is defined, it forwards EX/MEM and MEM/WB results into the operands.
module id_ex_operand_stage #(
   parameter int DATA_W = 32,
   parameter int FUNC_W = 6,
   parameter int REG_AW = 5
) (
   input logic                  clk,
   input logic                  rst_n,
   input logic                  flush,
   id_ex_operand_stage_if.slave bus
);

   typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

   state_e            state_q, state_d;
   logic              in_ready_s;
   logic              capture_s;
   logic [FUNC_W-1:0] func_q, func_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [REG_AW-1:0] rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
   logic              illegal_q, illegal_d;
   logic [DATA_W-1:0] a_cap_s, b_cap_s, a_hold_s, b_hold_s;

   function automatic logic func_illegal(input logic [FUNC_W-1:0] f);
      logic r;
      case (f)
         FUNC_W'(6'd0),  FUNC_W'(6'd2),  FUNC_W'(6'd4),  FUNC_W'(6'd6),  FUNC_W'(6'd7),
         FUNC_W'(6'd32), FUNC_W'(6'd33), FUNC_W'(6'd34), FUNC_W'(6'd35), FUNC_W'(6'd36),
         FUNC_W'(6'd37), FUNC_W'(6'd38), FUNC_W'(6'd39), FUNC_W'(6'd42), FUNC_W'(6'd43),
         FUNC_W'(6'd48), FUNC_W'(6'd50), FUNC_W'(6'd52), FUNC_W'(6'd54), FUNC_W'(6'd56): r = 1'b0;
         default: r = 1'b1;
      endcase
      return r;
   endfunction

`ifdef ID_EX_FWD_EN
   // EX/MEM is the younger producer, so it is checked before MEM/WB. Register 0 is never forwarded.
   function automatic logic [DATA_W-1:0] fwd_sel(
      input logic [REG_AW-1:0] src,
      input logic [DATA_W-1:0] dflt,
      input logic              exm_en,
      input logic [REG_AW-1:0] exm_dst,
      input logic [DATA_W-1:0] exm_val,
      input logic              wb_en,
      input logic [REG_AW-1:0] wb_dst,
      input logic [DATA_W-1:0] wb_val
   );
      logic [DATA_W-1:0] r;
      if ((src != {REG_AW{1'b0}}) && exm_en && (exm_dst == src)) begin
         r = exm_val;
      end else if ((src != {REG_AW{1'b0}}) && wb_en && (wb_dst == src)) begin
         r = wb_val;
      end else begin
         r = dflt;
      end
      return r;
   endfunction

   assign a_cap_s  = fwd_sel(bus.in_rs, bus.in_a, bus.exm_wr_en, bus.exm_rd, bus.exm_result,
                             bus.wb_wr_en, bus.wb_rd, bus.wb_result);
   assign b_cap_s  = fwd_sel(bus.in_rt, bus.in_b, bus.exm_wr_en, bus.exm_rd, bus.exm_result,
                             bus.wb_wr_en, bus.wb_rd, bus.wb_result);
   assign a_hold_s = fwd_sel(rs_q, a_q, bus.exm_wr_en, bus.exm_rd, bus.exm_result,
                             bus.wb_wr_en, bus.wb_rd, bus.wb_result);
   assign b_hold_s = fwd_sel(rt_q, b_q, bus.exm_wr_en, bus.exm_rd, bus.exm_result,
                             bus.wb_wr_en, bus.wb_rd, bus.wb_result);
`else
   logic unused_s;
   assign a_cap_s  = bus.in_a;
   assign b_cap_s  = bus.in_b;
   assign a_hold_s = a_q;
   assign b_hold_s = b_q;
   assign unused_s = ^{bus.exm_wr_en, bus.exm_rd, bus.exm_result,
                       bus.wb_wr_en, bus.wb_rd, bus.wb_result, rs_q, rt_q};
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; flush overrides every handshake outcome
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (bus.in_valid) state_d = ST_FULL;
               else              state_d = ST_EMPTY;
            end
            ST_FULL: begin
               if (bus.out_ready && !bus.in_valid) state_d = ST_EMPTY;
               else                                state_d = ST_FULL;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // Output logic: an empty stage always accepts, a full one only when the ALU drains it
   always_comb begin
      in_ready_s = 1'b1;
      case (state_q)
         ST_EMPTY: in_ready_s = 1'b1;
         ST_FULL:  in_ready_s = bus.out_ready;
         default:  in_ready_s = 1'b1;
      endcase
   end

   assign capture_s = bus.in_valid & in_ready_s & ~flush;

   // Field next-state: capture, refresh held operands, or keep
   always_comb begin
      func_d    = func_q;
      a_d       = a_q;
      b_d       = b_q;
      rd_d      = rd_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      illegal_d = illegal_q;
      if (flush) begin
         illegal_d = 1'b0;
      end else if (capture_s) begin
         func_d    = bus.in_func;
         a_d       = a_cap_s;
         b_d       = b_cap_s;
         rd_d      = bus.in_rd;
         rs_d      = bus.in_rs;
         rt_d      = bus.in_rt;
         illegal_d = func_illegal(bus.in_func);
      end else if (state_q == ST_FULL) begin
         a_d = a_hold_s;
         b_d = b_hold_s;
      end else begin
         a_d = a_q;
         b_d = b_q;
      end
   end

   // Field registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         func_q    <= {FUNC_W{1'b0}};
         a_q       <= {DATA_W{1'b0}};
         b_q       <= {DATA_W{1'b0}};
         rd_q      <= {REG_AW{1'b0}};
         rs_q      <= {REG_AW{1'b0}};
         rt_q      <= {REG_AW{1'b0}};
         illegal_q <= 1'b0;
      end else begin
         func_q    <= func_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rd_q      <= rd_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.in_ready     = in_ready_s;
   assign bus.out_valid    = (state_q == ST_FULL);
   assign bus.alu_func     = func_q;
   assign bus.alu_a        = a_q;
   assign bus.alu_b        = b_q;
   assign bus.alu_rd       = rd_q;
   assign bus.illegal_func = illegal_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios, then random traffic against a per-cycle reference model.
module tb_id_ex_operand_stage;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;

   always #5 clk = ~clk;

   id_ex_operand_stage_if bus ();

   id_ex_operand_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

`ifdef ID_EX_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;

   int unsigned legal_tab [20] = '{0, 2, 4, 6, 7, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 48, 50, 52, 54, 56};

   // reference model of the held instruction
   bit          m_valid;
   logic [5:0]  m_func;
   logic [31:0] m_a, m_b;
   logic [4:0]  m_rd, m_rs, m_rt;
   bit          m_ill;

   function automatic bit is_legal(input logic [5:0] f);
      foreach (legal_tab[i]) begin
         if (legal_tab[i] == 32'(f)) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_fwd(input logic [4:0] src, input logic [31:0] dflt);
      if (FWD && src != 5'd0 && bus.exm_wr_en && bus.exm_rd == src) return bus.exm_result;
      if (FWD && src != 5'd0 && bus.wb_wr_en && bus.wb_rd == src) return bus.wb_result;
      return dflt;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      flush = 1'b0;
      bus.in_valid = 1'b0;  bus.in_func = 6'd0;  bus.in_a = 32'd0;  bus.in_b = 32'd0;
      bus.in_rs = 5'd0;     bus.in_rt = 5'd0;    bus.in_rd = 5'd0;
      bus.exm_wr_en = 1'b0; bus.exm_rd = 5'd0;   bus.exm_result = 32'd0;
      bus.wb_wr_en = 1'b0;  bus.wb_rd = 5'd0;    bus.wb_result = 32'd0;
      bus.out_ready = 1'b0;
   endtask

   task automatic inst(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      bus.in_valid = 1'b1; bus.in_func = f; bus.in_a = a; bus.in_b = b;
      bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_func = 6'd0; m_a = 32'd0; m_b = 32'd0;
      m_rd = 5'd0; m_rs = 5'd0; m_rt = 5'd0; m_ill = 1'b0;
   endtask

   // one clock: check in_ready, advance the model with the current inputs, check outputs after the edge
   task automatic cycle();
      bit exp_ready;
      #1;
      exp_ready = !m_valid || bus.out_ready;
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
      if (flush) begin
         m_valid = 1'b0;
         m_ill   = 1'b0;
      end else if (bus.in_valid && exp_ready) begin
         m_valid = 1'b1;
         m_func  = bus.in_func;
         m_a     = m_fwd(bus.in_rs, bus.in_a);
         m_b     = m_fwd(bus.in_rt, bus.in_b);
         m_rs    = bus.in_rs;
         m_rt    = bus.in_rt;
         m_rd    = bus.in_rd;
         m_ill   = !is_legal(bus.in_func);
      end else if (m_valid && bus.out_ready) begin
         m_valid = 1'b0;
      end else if (m_valid) begin
         m_a = m_fwd(m_rs, m_a);
         m_b = m_fwd(m_rt, m_b);
      end
      @(posedge clk);
      #1;
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      if (m_valid) begin
         chk("alu_func", {26'd0, bus.alu_func}, {26'd0, m_func});
         chk("alu_a", bus.alu_a, m_a);
         chk("alu_b", bus.alu_b, m_b);
         chk("alu_rd", {27'd0, bus.alu_rd}, {27'd0, m_rd});
         chk("illegal_func", {31'd0, bus.illegal_func}, {31'd0, m_ill});
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_alu_a", bus.alu_a, 32'd0);
      chk("rst_alu_func", {26'd0, bus.alu_func}, 32'd0);
      chk("rst_illegal", {31'd0, bus.illegal_func}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      rst_n = 1'b1;

      // basic capture
      inst(6'd33, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3);
      bus.out_ready = 1'b1;
      cycle();
      chk("cap_a", bus.alu_a, 32'd5);
      chk("cap_b", bus.alu_b, 32'd7);
      chk("cap_rd", {27'd0, bus.alu_rd}, 32'd3);

      // forward priority, back-to-back capture
      inst(6'd32, 32'h11, 32'h22, 5'd4, 5'd0, 5'd6);
      bus.exm_wr_en = 1'b1; bus.exm_rd = 5'd4; bus.exm_result = 32'hAA;
      bus.wb_wr_en  = 1'b1; bus.wb_rd  = 5'd4; bus.wb_result  = 32'hBB;
      cycle();
      chk("fwd_prio_a", bus.alu_a, FWD ? 32'hAA : 32'h11);

      // register 0 is never forwarded
      inst(6'd34, 32'h33, 32'h44, 5'd0, 5'd0, 5'd7);
      bus.exm_rd = 5'd0; bus.wb_rd = 5'd0;
      cycle();
      chk("fwd_r0_a", bus.alu_a, 32'h33);

      // stall refresh
      idle();
      inst(6'd35, 32'h66, 32'h55, 5'd0, 5'd9, 5'd10);
      bus.out_ready = 1'b1;
      cycle();
      inst(6'd2, 32'h77, 32'h88, 5'd1, 5'd1, 5'd1);
      bus.out_ready = 1'b0;
      bus.wb_wr_en = 1'b1; bus.wb_rd = 5'd9; bus.wb_result = 32'h1234;
      #1 chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      cycle();
      chk("stall_b", bus.alu_b, FWD ? 32'h1234 : 32'h55);
      chk("stall_func", {26'd0, bus.alu_func}, 32'd35);
      bus.wb_wr_en = 1'b0;
      cycle();
      chk("stall_in_ready2", {31'd0, bus.in_ready}, 32'd0);

      // flush drops both held and incoming instruction
      flush = 1'b1;
      cycle();
      chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("flush_illegal", {31'd0, bus.illegal_func}, 32'd0);
      idle();
      cycle();
      chk("flush_no_capture", {31'd0, bus.out_valid}, 32'd0);

      // illegal function code
      inst(6'd61, 32'd1, 32'd2, 5'd0, 5'd0, 5'd5);
      bus.out_ready = 1'b1;
      cycle();
      chk("illegal_61", {31'd0, bus.illegal_func}, 32'd1);
      chk("illegal_61_valid", {31'd0, bus.out_valid}, 32'd1);
      inst(6'd36, 32'd3, 32'd4, 5'd0, 5'd0, 5'd6);
      cycle();
      chk("legal_36", {31'd0, bus.illegal_func}, 32'd0);

      // drain to empty
      bus.in_valid = 1'b0;
      cycle();
      chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         bus.in_valid   = ($urandom_range(0, 3) != 0);
         bus.out_ready  = ($urandom_range(0, 2) != 0);
         flush          = ($urandom_range(0, 15) == 0);
         bus.in_func    = ($urandom_range(0, 1) == 1) ? 6'(legal_tab[$urandom_range(0, 19)])
                                                      : 6'($urandom_range(0, 63));
         bus.in_a       = $urandom();
         bus.in_b       = $urandom();
         bus.in_rs      = 5'($urandom_range(0, 3));
         bus.in_rt      = 5'($urandom_range(0, 3));
         bus.in_rd      = 5'($urandom_range(0, 31));
         bus.exm_wr_en  = 1'($urandom_range(0, 1));
         bus.exm_rd     = 5'($urandom_range(0, 3));
         bus.exm_result = $urandom();
         bus.wb_wr_en   = 1'($urandom_range(0, 1));
         bus.wb_rd      = 5'($urandom_range(0, 3));
         bus.wb_result  = $urandom();
         cycle();
      end

      // asynchronous reset while holding an instruction
      idle();
      inst(6'd61, 32'hDEAD, 32'hBEEF, 5'd0, 5'd0, 5'd12);
      bus.out_ready = 1'b1;
      cycle();
      chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
      idle();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("arst_alu_a", bus.alu_a, 32'd0);
      chk("arst_alu_b", bus.alu_b, 32'd0);
      chk("arst_func", {26'd0, bus.alu_func}, 32'd0);
      chk("arst_rd", {27'd0, bus.alu_rd}, 32'd0);
      chk("arst_illegal", {31'd0, bus.illegal_func}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
